// File: rtl/butterfly_dmem_responder.sv
// Data-memory responder: one access in flight, fixed wait states, byte-strobed writes.
// Define BUTTERFLY_DMEM_ERR_EN to add dmem_err_o (out-of-range or misaligned-write accesses).
module butterfly_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmem_valid_i,
  input  logic        dmem_write_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_wstrb_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_ready_o
`ifdef BUTTERFLY_DMEM_ERR_EN
  ,
  output logic        dmem_err_o
`endif
);

  // state   | meaning
  // ST_IDLE | waiting for a request; only state that accepts one
  // ST_WAIT | access latched, counting down wait states
  // ST_RESP | one-cycle completion: ready pulse, read data, write commit

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept;
  logic          write_q;
  logic [31:2]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          in_range;
  logic          access_ok;
  logic          resp;
  logic          do_write;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= dmem_write_i;
        addr_q  <= dmem_addr_i[31:2];
        wdata_q <= dmem_wdata_i;
        wstrb_q <= dmem_wstrb_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dmem_valid_i) begin
          accept  = 1'b1;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_LOAD == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // leave on the edge where the counter terminates at zero
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign idx      = addr_q[AW+1:2];
  assign in_range = (addr_q[31:AW+2] == '0);
  assign resp     = (state_q == ST_RESP);

`ifdef BUTTERFLY_DMEM_ERR_EN
  logic misalign_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       misalign_q <= 1'b0;
    else if (accept) misalign_q <= dmem_write_i && (dmem_addr_i[1:0] != 2'b00);
  end

  assign access_ok  = in_range && !misalign_q;
  assign dmem_err_o = resp && !access_ok;
`else
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^dmem_addr_i[1:0];
  assign access_ok       = in_range;
`endif

  assign dmem_ready_o = resp;
  assign do_write     = resp && write_q && access_ok;
  assign dmem_rdata_o = (resp && !write_q && access_ok) ? mem[idx] : 32'h0000_0000;

  // no reset: contents survive rst_i; an aborted access never reaches ST_RESP
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_butterfly_dmem_responder.sv
// Scoreboard bench for butterfly_dmem_responder: a 1-wait-state 1024-word instance
// and a 0-wait-state 16-word instance, each checked against a reference memory.
module tb_butterfly_dmem_responder;

  localparam int W_A     = 1;
  localparam int DEPTH_A = 1024;
  localparam int AW_A    = $clog2(DEPTH_A);
  localparam int W_B     = 0;
  localparam int DEPTH_B = 16;
  localparam int AW_B    = $clog2(DEPTH_B);
`ifdef BUTTERFLY_DMEM_ERR_EN
  localparam bit ERR_EN  = 1'b1;
`else
  localparam bit ERR_EN  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_valid = 1'b0, a_write = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, a_rdata;
  logic [3:0]  a_wstrb = '0;
  logic        a_ready;
  logic        b_valid = 1'b0, b_write = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0, b_rdata;
  logic [3:0]  b_wstrb = '0;
  logic        b_ready;
`ifdef BUTTERFLY_DMEM_ERR_EN
  logic        a_err, b_err;
  bit          qa_err[$];
  bit          qb_err[$];
`endif

  logic [31:0] ref_a [DEPTH_A];
  logic [31:0] ref_b [DEPTH_B];
  logic [31:0] qa_data[$];
  logic [31:0] qb_data[$];
  int          b_last_ready = 0;

  butterfly_dmem_responder #(.DEPTH_WORDS(DEPTH_A), .WAIT_CYCLES(W_A)) u_dut_a (
    .clk_i        (clk),
    .rst_i        (rst),
    .dmem_valid_i (a_valid),
    .dmem_write_i (a_write),
    .dmem_addr_i  (a_addr),
    .dmem_wdata_i (a_wdata),
    .dmem_wstrb_i (a_wstrb),
    .dmem_rdata_o (a_rdata),
    .dmem_ready_o (a_ready)
`ifdef BUTTERFLY_DMEM_ERR_EN
    ,
    .dmem_err_o   (a_err)
`endif
  );

  butterfly_dmem_responder #(.DEPTH_WORDS(DEPTH_B), .WAIT_CYCLES(W_B)) u_dut_b (
    .clk_i        (clk),
    .rst_i        (rst),
    .dmem_valid_i (b_valid),
    .dmem_write_i (b_write),
    .dmem_addr_i  (b_addr),
    .dmem_wdata_i (b_wdata),
    .dmem_wstrb_i (b_wstrb),
    .dmem_rdata_o (b_rdata),
    .dmem_ready_o (b_ready)
`ifdef BUTTERFLY_DMEM_ERR_EN
    ,
    .dmem_err_o   (b_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model update plus request drive for instance A; drop releases
  // valid and scrambles the request fields right after accept.
  task automatic a_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input bit drop);
    int n;
    int idx;
    bit inr, ok;
    inr = ((addr >> (AW_A + 2)) == 32'd0);
    ok  = inr && !(ERR_EN && wr && (addr[1:0] != 2'b00));
    idx = int'((addr >> 2) & 32'(DEPTH_A - 1));
    if (wr) begin
      if (ok) for (int b = 0; b < 4; b++) if (strb[b]) ref_a[idx][8*b +: 8] = wdata[8*b +: 8];
      qa_data.push_back(32'h0);
    end else begin
      qa_data.push_back(ok ? ref_a[idx] : 32'h0);
    end
`ifdef BUTTERFLY_DMEM_ERR_EN
    qa_err.push_back(!ok);
`endif
    @(negedge clk);
    a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wdata; a_wstrb = strb;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop && n == 1) begin
        a_valid = 1'b0; a_write = ~wr; a_addr = ~addr; a_wdata = ~wdata; a_wstrb = ~strb;
      end
    end while (!a_ready && n < 40);
    check("a_latency", n, W_A + 1);
    a_valid = 1'b0;
  endtask

  task automatic b_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input bit chk_interval);
    int n;
    int idx;
    bit inr, ok;
    inr = ((addr >> (AW_B + 2)) == 32'd0);
    ok  = inr && !(ERR_EN && wr && (addr[1:0] != 2'b00));
    idx = int'((addr >> 2) & 32'(DEPTH_B - 1));
    if (wr) begin
      if (ok) for (int b = 0; b < 4; b++) if (strb[b]) ref_b[idx][8*b +: 8] = wdata[8*b +: 8];
      qb_data.push_back(32'h0);
    end else begin
      qb_data.push_back(ok ? ref_b[idx] : 32'h0);
    end
`ifdef BUTTERFLY_DMEM_ERR_EN
    qb_err.push_back(!ok);
`endif
    @(negedge clk);
    b_valid = 1'b1; b_write = wr; b_addr = addr; b_wdata = wdata; b_wstrb = strb;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_ready && n < 40);
    check("b_latency", n, W_B + 1);
    if (chk_interval) check("b_interval", cyc - b_last_ready, 2);
    b_last_ready = cyc;
    b_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a_ready) begin
        if (qa_data.size() == 0) check("a_unexpected_ready", 32'd1, 32'd0);
        else begin
          check("a_rdata", a_rdata, qa_data.pop_front());
`ifdef BUTTERFLY_DMEM_ERR_EN
          check("a_err", 32'(a_err), 32'(qa_err.pop_front()));
`endif
        end
      end else begin
        check("a_rdata_idle", a_rdata, 32'h0);
      end
      if (b_ready) begin
        if (qb_data.size() == 0) check("b_unexpected_ready", 32'd1, 32'd0);
        else begin
          check("b_rdata", b_rdata, qb_data.pop_front());
`ifdef BUTTERFLY_DMEM_ERR_EN
          check("b_err", 32'(b_err), 32'(qb_err.pop_front()));
`endif
        end
      end else begin
        check("b_rdata_idle", b_rdata, 32'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    repeat (2) @(negedge clk);
    check("rst_a_ready", 32'(a_ready), 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_ready", 32'(b_ready), 32'h0);
    rst = 1'b0;

    a_access(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b0);
    a_access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
    a_access(1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0);
    a_access(1'b1, 32'h0000_0010, 32'h0000_AA00, 4'h2, 1'b0);
    a_access(1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0);
    a_access(1'b1, 32'h0000_0014, 32'hA5A5_A5A5, 4'hF, 1'b0);
    a_access(1'b1, 32'h0000_0014, 32'h1122_3344, 4'h0, 1'b0);
    a_access(1'b0, 32'h0000_0014, 32'h0,         4'h0, 1'b0);
    a_access(1'b0, 32'h0000_1000, 32'h0,         4'h0, 1'b0);
    a_access(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 1'b0);
    a_access(1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b0);
    a_access(1'b0, 32'h0000_0013, 32'h0,         4'h0, 1'b0);
    a_access(1'b1, 32'h0000_0016, 32'h0000_00EE, 4'h1, 1'b0);
    a_access(1'b0, 32'h0000_0014, 32'h0,         4'h0, 1'b0);
    a_access(1'b0, 32'h8000_0010, 32'h0,         4'h0, 1'b0);
    a_access(1'b1, 32'h0000_0FFC, 32'h0BAD_CAFE, 4'hF, 1'b0);
    a_access(1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 1'b0);
    a_access(1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1);
    a_access(1'b1, 32'h0000_0024, 32'h600D_F00D, 4'hF, 1'b1);
    a_access(1'b0, 32'h0000_0024, 32'h0,         4'h0, 1'b0);

    // short async reset pulse while a write sits in the wait state
    a_access(1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 1'b0);
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h20; a_wdata = 32'h5555_5555; a_wstrb = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    a_valid = 1'b0;
    #1;
    check("rst_pulse_ready", 32'(a_ready), 32'h0);
    check("rst_pulse_rdata", a_rdata, 32'h0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_abort_no_ready", 32'(a_ready), 32'h0);
    end
    a_access(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0);

    for (int i = 0; i < 16; i++) a_access(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);
    for (int i = 0; i < 30; i++) begin
      addr = 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = addr | 32'h0000_1000;
      a_access(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end

    for (int i = 0; i < 4; i++) b_access(1'b1, 32'(i * 4), 32'hB000_0000 + 32'(i), 4'hF, i > 0);
    b_access(1'b1, 32'h0000_003C, 32'h7E57_0F0F, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) b_access(1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b1);
    b_access(1'b0, 32'h0000_003C, 32'h0, 4'h0, 1'b1);
    b_access(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b1);
    b_access(1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'hF, 1'b1);
    b_access(1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b1);

    repeat (3) @(negedge clk);
    check("a_scoreboard_empty", 32'(qa_data.size()), 32'h0);
    check("b_scoreboard_empty", 32'(qb_data.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
